// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dmem_state_e;

  localparam int unsigned LatMin = 1;
  localparam int unsigned LatMax = 8;
  // Counter only ever holds LATENCY-1, so it never needs to represent LatMax itself.
  localparam int unsigned CntW   = $clog2(LatMax);

  typedef logic [CntW-1:0] cnt_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous byte-enabled write, registered read.
module dmem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Storage itself has no reset so contents survive RSTn.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else if (rclr) begin
      rdata <= 32'd0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency request/acknowledge handshake
// in front of a byte-enabled word RAM, with illegal-address detection.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ReqM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic [31:0] ReadDataM,
  output logic        AckM,
  output logic        BusyM,
  output logic        ErrM
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam cnt_t        CntInit = cnt_t'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        cap_we_q;
  logic [31:0] cap_addr_q, cap_wdata_q;
  logic [3:0]  cap_be_q;
  logic        err_q;

  logic        go_resp, legal;
  logic        eff_we;
  logic [31:0] eff_addr, eff_wdata;
  logic [3:0]  eff_be;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    BusyM   = 1'b0;
    AckM    = 1'b0;
    ErrM    = 1'b0;
    unique case (state_q)
      StIdle: begin
        BusyM = ReqM;
        if (ReqM) begin
          if (LATENCY <= LatMin) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        BusyM = 1'b1;
        if (cnt_q == cnt_t'(1)) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StResp: begin
        // ReqM here still belongs to the completing access.
        AckM    = 1'b1;
        ErrM    = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY=1 the access happens on the capture edge, so use the live inputs.
  always_comb begin
    go_resp   = (state_d == StResp) && (state_q != StResp);
    eff_we    = (state_q == StIdle) ? MemWriteM  : cap_we_q;
    eff_addr  = (state_q == StIdle) ? AddrM      : cap_addr_q;
    eff_wdata = (state_q == StIdle) ? WriteDataM : cap_wdata_q;
    eff_be    = (state_q == StIdle) ? ByteEnM    : cap_be_q;
    legal     = (eff_addr[1:0] == 2'b00) && ((eff_addr >> (AW + 2)) == 32'd0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'd0;
      cap_wdata_q <= 32'd0;
      cap_be_q    <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && ReqM) begin
        cap_we_q    <= MemWriteM;
        cap_addr_q  <= AddrM;
        cap_wdata_q <= WriteDataM;
        cap_be_q    <= ByteEnM;
      end
      if (go_resp) err_q <= ~legal;
    end
  end

  dmem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (CLK),
    .rst_n(RSTn),
    .we   (go_resp & eff_we & legal),
    .re   (go_resp & ~eff_we & legal),
    .rclr (go_resp & ~legal),
    .addr (eff_addr[AW+1:2]),
    .wdata(eff_wdata),
    .be   (eff_be),
    .rdata(ReadDataM)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances at LATENCY 2, 1, 8 and 4.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [3:0]  req;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [3:0]  ack, busy, err;
  logic [31:0] rdata [4];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lat_of [4] = '{2, 1, 8, 4};
  int busy_run [4] = '{0, 0, 0, 0};

  typedef struct {
    int          dut;
    int          cyc;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb [$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (256),
      .LATENCY(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 8 : 4)
    ) u_dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .ReqM      (req[g]),
      .MemWriteM (we),
      .AddrM     (addr),
      .WriteDataM(wdata),
      .ByteEnM   (be),
      .ReadDataM (rdata[g]),
      .AckM      (ack[g]),
      .BusyM     (busy[g]),
      .ErrM      (err[g])
    );
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every acknowledge pops one expected response.
  always @(negedge CLK) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (ack[i] !== 1'b0) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_ack_dut%0d", i), {31'd0, ack[i]}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_dut", i, e.dut);
          chk("ack_cycle", cyc, e.cyc);
          chk("err", {31'd0, err[i]}, {31'd0, e.err});
          if (e.chk) chk("rdata", rdata[i], e.data);
          chk("busy_len", busy_run[i], lat_of[i]);
        end
      end
      busy_run[i] = (busy[i] === 1'b1) ? busy_run[i] + 1 : 0;
    end
  end

  task automatic drive(int d, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] b,
                       logic e_err, logic e_chk, logic [31:0] e_data);
    exp_t e;
    we     = w;
    addr   = a;
    wdata  = wd;
    be     = b;
    req[d] = 1'b1;
    e.dut  = d;
    e.cyc  = cyc + lat_of[d];
    e.err  = e_err;
    e.chk  = e_chk;
    e.data = e_data;
    sb.push_back(e);
  endtask

  task automatic wait_ack(int d);
    bit got = 1'b0;
    for (int k = 0; k < 32 && !got; k++) begin
      @(negedge CLK);
      if (ack[d] === 1'b1) got = 1'b1;
    end
    if (!got) chk("ack_timeout", {31'd0, ack[d]}, 32'd1);
  endtask

  task automatic access(int d, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] b,
                        logic e_err, logic e_chk, logic [31:0] e_data);
    @(posedge CLK);
    #1;
    drive(d, w, a, wd, b, e_err, e_chk, e_data);
    wait_ack(d);
    @(posedge CLK);
    #1;
    req[d] = 1'b0;
  endtask

  initial begin
    RSTn  = 1'b0;
    req   = 4'd0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    be    = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_ack", {31'd0, ack[i]}, 32'd0);
      chk("reset_err", {31'd0, err[i]}, 32'd0);
      chk("reset_rdata", rdata[i], 32'd0);
      chk("reset_busy", {31'd0, busy[i]}, 32'd0);
    end
    req[0] = 1'b1;
    #1;
    chk("busy_follows_req_in_reset", {31'd0, busy[0]}, 32'd1);
    req[0] = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // Store then load at LATENCY=2.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Partial store.
    access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0);
    access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 32'h0);
    access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11BB33DD);
    // Empty byte enable still acknowledges and leaves memory alone.
    access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Illegal accesses: misaligned load, out-of-range store aliasing word 0.
    access(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
    access(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, 1'b0, 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h01020304);
    access(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h01020304);
    // Latency extremes.
    access(1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'h0);
    access(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A5A5A5);
    access(2, 1'b1, 32'h44, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, 32'h0);
    access(2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5A5A5A5A);

    // Back-to-back: ReqM held across the acknowledge, next access in the following cycle.
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    wait_ack(0);
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 32'h14, 32'h0BADCAFE, 4'hF, 1'b0, 1'b0, 32'h0);
    wait_ack(0);
    @(posedge CLK);
    #1;
    req[0] = 1'b0;
    access(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BADCAFE);

    // Reset in the second WAIT cycle of a LATENCY=4 store aborts it.
    access(3, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0);
    access(3, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    @(posedge CLK);
    #1;
    we     = 1'b1;
    addr   = 32'h30;
    wdata  = 32'h12345678;
    be     = 4'hF;
    req[3] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RSTn   = 1'b0;
    req[3] = 1'b0;
    #1;
    chk("abort_ack", {31'd0, ack[3]}, 32'd0);
    chk("abort_rdata_cleared", rdata[3], 32'd0);
    chk("abort_busy", {31'd0, busy[3]}, 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    access(3, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    repeat (5) @(posedge CLK);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
